vram_slot_arbiter: RTL and testbench
====================================

# vram_slot_arbiter

Time-slot arbiter that shares the single-port video RAM between the ULA video fetch path and the Z80 CPU. It advances a slot counter on each `tick` pulse from the pixel-clock divider. On every slot boundary it grants the RAM to at most one requester, with video owning a fixed window of slots during active display. It sits between the divider chain, the ULA fetch logic, the CPU bus interface and the VRAM block.

## Interface
- `ADDR_BITS`, 14, VRAM address width
- `DATA_BITS`, 8, VRAM data width
- `SLOT_BITS`, 3, slot counter width
- `SLOT_MOD`, 8, slots per cycle; must be ≤ 2^SLOT_BITS
- `VID_SLOTS`, 4, slots 0..VID_SLOTS-1 form the video window; must be < SLOT_MOD

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `tick`  in  1  one-clk slot-advance strobe; ticks are ≥3 clk apart
- `display_active`  in  1  ULA is in the active display area; sampled only on tick
- `vid_req`  in  1  video fetch request, level
- `vid_addr`  in  ADDR_BITS  video fetch address
- `vid_ack`  out  1  one-clk pulse, `vid_data` valid
- `vid_data`  out  DATA_BITS  fetched byte, registered
- `cpu_req`  in  1  CPU access request, level
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_BITS  CPU address
- `cpu_wdata`  in  DATA_BITS  CPU write data
- `cpu_ack`  out  1  one-clk pulse, access complete
- `cpu_rdata`  out  DATA_BITS  read data, registered
- `cpu_wait`  out  1  `cpu_req & ~cpu_ack`, combinational; drives CPU WAIT
- `mem_addr`  out  ADDR_BITS  VRAM address
- `mem_we`  out  1  VRAM write enable
- `mem_wdata`  out  DATA_BITS  VRAM write data
- `mem_rdata`  in  DATA_BITS  VRAM read data; synchronous RAM with 1-clk latency
- `slot`  out  SLOT_BITS  current slot number

## Operation
- Slot counter: increments on each clock edge where `tick`=1 and wraps from SLOT_MOD-1 to 0. The grant decision uses the new (post-increment) slot value `slot_n`.
- FSM states: IDLE, ADDR, DATA, ACK. The owner register (VID or CPU) is latched on entry to ADDR.
- IDLE + tick: the grant is chosen as follows.
  - `display_active`=1 and `slot_n` < VID_SLOTS:
    - `vid_req` → VID.
    - Otherwise `cpu_req` → CPU. The CPU may steal an idle video slot.
  - `display_active`=1 and `slot_n` ≥ VID_SLOTS:
    - `cpu_req` → CPU.
    - Video is never granted.
  - `display_active`=0:
    - `cpu_req` → CPU.
    - Otherwise `vid_req` → VID.
  - No eligible request → stay in IDLE.
- ADDR, 1 clk:
  - `mem_addr` = owner address.
  - `mem_we` = `cpu_we` when the owner is CPU, else 0.
  - `mem_wdata` = `cpu_wdata`.
- DATA, 1 clk: `mem_we`=0 and `mem_addr` is held. At the end of DATA, `mem_rdata` is registered into the owner's data output.
- ACK, 1 clk: the owner's ack is high, then the FSM returns to IDLE.
- A CPU write also passes through DATA and ACK. `cpu_rdata` is still updated with the RAM output, which is don't-care.
- Requesters hold req, addr and wdata stable until their ack. A request dropped before grant is never serviced. Once a request is granted, the access completes even if req drops.
- A tick that arrives while the FSM is not in IDLE still advances `slot`, but that slot is lost and no grant is made.
- `vid_data` and `cpu_rdata` keep their value until the next completed access of the same owner.
- Reset, including mid-access:
  - All outputs go to 0 immediately and the FSM goes to IDLE.
  - The slot counter goes to 0.
  - No ack is issued for the aborted access.

## Timing
- Tick sampled at edge n → after edge n: ADDR, `mem_we` is high for writes.
- After edge n+1: DATA.
- Edge n+2: read data captured. After edge n+2: ack high.
- After edge n+3: IDLE.
- Latency from grant tick to ack is 2 clk. Total occupancy is 3 clk.
- A grant can only follow a tick, so worst-case CPU wait during display is `VID_SLOTS` lost slots plus up to one slot of alignment.
- `cpu_wait` asserts in the same cycle `cpu_req` rises and deasserts during the `cpu_ack` cycle.
- When neither requester owns the RAM, the interface idles at `mem_addr`=0 and `mem_we`=0.

## Test plan
- **Reset:** reset held with random inputs, then release. Expected: `slot`=0, `mem_we`=0, both acks 0, `cpu_wait` follows `cpu_req`.
- **Video window:** `display_active`=1, `vid_req` and `cpu_req` both asserted, tick every 4 clk. Expected:
  - Slots 0–3 ack video. Slots 4–7 ack CPU.
  - `vid_data` equals preloaded RAM[`vid_addr`] = 0xA5 two clk after the grant tick.
- **Slot stealing:** `display_active`=1, only `cpu_req` asserted, read 0x1234. Expected: granted at the very next tick whatever the slot; `cpu_rdata`=RAM[0x1234].
- **CPU write:** `cpu_we`=1, `cpu_addr`=0x0100, `cpu_wdata`=0x3C. Expected:
  - `mem_we` high for exactly 1 clk with `mem_addr`=0x0100.
  - A following read returns 0x3C.
- **Lost slot and wrap:** ticks 2 clk apart. Expected: every second tick produces no grant; `slot` wraps from 7 to 0 correctly.
- **Reset mid-access:** assert reset in DATA. Expected: no ack, `mem_we`=0 immediately, and the next access after release completes normally.

Source files
------------

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing a single-port VRAM between ULA video fetch and the Z80 CPU.
// Each tick advances the slot counter and may grant one three-cycle access: ADDR, DATA, ACK.
module vram_slot_arbiter #(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SLOT_BITS = 3,
  parameter int unsigned SLOT_MOD  = 8,
  parameter int unsigned VID_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 display_active,
  input  logic                 vid_req,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic                 vid_ack,
  output logic [DATA_BITS-1:0] vid_data,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATA_BITS-1:0] cpu_rdata,
  output logic                 cpu_wait,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [SLOT_BITS-1:0] slot
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StAck  = 2'd3;

  localparam logic OwnVid = 1'b0;
  localparam logic OwnCpu = 1'b1;

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [DATA_BITS-1:0] vid_data_q, vid_data_d;
  logic [DATA_BITS-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [SLOT_BITS-1:0] slot_n;
  logic                 in_vid_window;
  logic                 grant_vid;
  logic                 grant_cpu;

  always_comb begin
    slot_n = (slot_q == SLOT_BITS'(SLOT_MOD - 1)) ? '0 : slot_q + 1'b1;
    in_vid_window = display_active && (slot_n < SLOT_BITS'(VID_SLOTS));
    // Video wins its window; CPU may steal an unused video slot. In blanking, CPU has priority.
    grant_vid = in_vid_window ? vid_req : (!display_active && !cpu_req && vid_req);
    grant_cpu = in_vid_window ? (!vid_req && cpu_req) : cpu_req;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    slot_d      = tick ? slot_n : slot_q;

    unique case (state_q)
      StIdle: begin
        if (tick && (grant_vid || grant_cpu)) begin
          state_d = StAddr;
          owner_d = grant_cpu ? OwnCpu : OwnVid;
          addr_d  = grant_cpu ? cpu_addr : vid_addr;
          we_d    = grant_cpu && cpu_we;
          wdata_d = cpu_wdata;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        state_d = StAck;
        if (owner_q == OwnCpu) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          vid_data_d = mem_rdata;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnVid;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      slot_q      <= '0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      slot_q      <= slot_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Bus is parked at address 0 with no write whenever no access is in its ADDR/DATA phase.
  always_comb begin
    mem_addr  = ((state_q == StAddr) || (state_q == StData)) ? addr_q : '0;
    mem_we    = (state_q == StAddr) && we_q;
    mem_wdata = ((state_q == StAddr) && (owner_q == OwnCpu)) ? wdata_q : '0;
    vid_ack   = (state_q == StAck) && (owner_q == OwnVid);
    cpu_ack   = (state_q == StAck) && (owner_q == OwnCpu);
    cpu_wait  = cpu_req && !cpu_ack;
    vid_data  = vid_data_q;
    cpu_rdata = cpu_rdata_q;
    slot      = slot_q;
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: a synchronous RAM model, a slot/occupancy reference model,
// a table of grant decisions, directed multi-cycle sequences and randomized traffic.
module tb_vram_slot_arbiter;

  localparam int AB = 14;
  localparam int DB = 8;
  localparam int SB = 3;
  localparam int SM = 8;
  localparam int VS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          display_active = 1'b0;
  logic          vid_req = 1'b0;
  logic [AB-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [DB-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AB-1:0] cpu_addr = '0;
  logic [DB-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DB-1:0] cpu_rdata;
  logic          cpu_wait;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [DB-1:0] mem_wdata;
  logic [DB-1:0] mem_rdata;
  logic [SB-1:0] slot;

  vram_slot_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .SLOT_BITS(SB), .SLOT_MOD(SM), .VID_SLOTS(VS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .display_active(display_active),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .slot(slot)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write; pl_* preloads it while the DUT is in reset.
  logic [DB-1:0] ram [0:16383];
  logic          pl_en = 1'b0;
  logic [AB-1:0] pl_addr = '0;
  logic [DB-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  logic [DB-1:0] shadow [0:16383];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot number, the edge of the last grant and the first edge a new grant may
  // happen at. Owner codes: 1 = video, 2 = CPU.
  int            cyc = 0;
  int            m_slot = 0;
  int            m_g = -100;
  int            m_free = 0;
  int            m_owner = 0;
  bit            m_we = 0;
  logic [AB-1:0] m_addr = '0;
  logic [DB-1:0] m_wd = '0;
  logic [DB-1:0] m_pend = '0;
  logic [DB-1:0] m_vid = '0;
  logic [DB-1:0] m_cpu = '0;
  bit            m_cpu_dc = 0;
  bit            drop_on_ack = 0;
  int            c_vack = 0;
  int            c_cack = 0;
  int            c_we = 0;

  function automatic int decide(input bit d, input int sn, input bit v, input bit c);
    if (d && sn < VS) return v ? 1 : (c ? 2 : 0);
    if (d) return c ? 2 : 0;
    return c ? 2 : (v ? 1 : 0);
  endfunction

  // Apply current inputs at the next rising edge, then check every output against the model.
  task automatic step();
    bit            t = tick;
    bit            d = display_active;
    bit            v = vid_req;
    bit            c = cpu_req;
    bit            w = cpu_we;
    logic [AB-1:0] va = vid_addr;
    logic [AB-1:0] ca = cpu_addr;
    logic [DB-1:0] wd = cpu_wdata;
    int            g;
    int            ph;
    @(posedge clk);
    cyc++;
    if (t) begin
      m_slot = (m_slot + 1) % SM;
      if (cyc >= m_free) begin
        g = decide(d, m_slot, v, c);
        if (g != 0) begin
          m_owner = g;
          m_g     = cyc;
          m_free  = cyc + 4;
          m_addr  = (g == 2) ? ca : va;
          m_we    = (g == 2) && w;
          m_wd    = wd;
          if (m_we) shadow[ca] = wd;
          else m_pend = shadow[m_addr];
        end
      end
    end
    #1 tick = 1'b0;
    ph = cyc - m_g;
    if (ph == 2) begin
      if (m_owner == 1) m_vid = m_pend;
      else if (m_we) m_cpu_dc = 1;
      else begin
        m_cpu    = m_pend;
        m_cpu_dc = 0;
      end
    end
    check("slot", slot, m_slot);
    check("mem_addr", mem_addr, (ph == 0 || ph == 1) ? m_addr : '0);
    check("mem_we", mem_we, (ph == 0) && m_we);
    if (ph == 0 && m_we) check("mem_wdata", mem_wdata, m_wd);
    check("vid_ack", vid_ack, (ph == 2) && (m_owner == 1));
    check("cpu_ack", cpu_ack, (ph == 2) && (m_owner == 2));
    check("cpu_wait", cpu_wait, cpu_req && !((ph == 2) && (m_owner == 2)));
    check("vid_data", vid_data, m_vid);
    if (!m_cpu_dc) check("cpu_rdata", cpu_rdata, m_cpu);
    if (vid_ack === 1'b1) c_vack++;
    if (cpu_ack === 1'b1) c_cack++;
    if (mem_we === 1'b1 && mem_addr == 14'h0100) c_we++;
    if (drop_on_ack) begin
      if (vid_ack) vid_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
    end
  endtask

  task automatic tick_gap(input int gap);
    tick = 1'b1;
    repeat (gap) step();
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    tick           = 1'($urandom);
    display_active = 1'($urandom);
    vid_req        = 1'($urandom);
    cpu_req        = 1'($urandom);
    cpu_we         = 1'($urandom);
    vid_addr       = AB'($urandom);
    cpu_addr       = AB'($urandom);
    cpu_wdata      = DB'($urandom);
    #1;
    check("rst_slot", slot, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_acks", {vid_ack, cpu_ack}, 0);
    check("rst_cpu_wait", cpu_wait, cpu_req);
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold_slot", slot, 0);
    check("rst_hold_data", {vid_data, cpu_rdata}, 0);
    check("rst_hold_wait", cpu_wait, cpu_req);
    {tick, display_active, vid_req, cpu_req, cpu_we} = '0;
    vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    reset    = 1'b0;
    m_slot = 0; m_g = -100; m_free = 0; m_owner = 0; m_we = 0;
    m_vid = '0; m_cpu = '0; m_cpu_dc = 0;
  endtask

  typedef struct {
    bit disp;
    bit vreq;
    bit creq;
    int slot_n;
    bit exp_vid;
    bit exp_cpu;
  } vec_t;

  vec_t vt [10];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int gap;
    vt[0] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0};
    vt[5] = '{0,    1'b1, 1'b1, 2, 1'b0, 1'b1};
    vt[6] = '{0,    1'b1, 1'b0, 6, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vt[9] = '{1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b1};

    // Preload the address pool while the DUT is held in reset.
    for (int i = 0; i < 18; i++) begin
      pl_en   = 1'b1;
      pl_addr = (i < 16) ? AB'(14'h1230 + i) : ((i == 16) ? 14'h0100 : 14'h0800);
      pl_data = (i == 4) ? 8'h5A : ((i == 17) ? 8'hA5 : DB'($urandom));
      shadow[pl_addr] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    do_reset(3);

    for (int i = 0; i < 10; i++) begin
      do_reset(2);
      vid_addr = 14'h0800;
      cpu_addr = 14'h1234;
      display_active = vt[i].disp;
      n = (vt[i].slot_n == 0) ? SM : vt[i].slot_n;
      for (int k = 0; k < n - 1; k++) tick_gap(4);
      vid_req = vt[i].vreq;
      cpu_req = vt[i].creq;
      tick_gap(3);
      check($sformatf("vec%0d_vid_ack", i), vid_ack, vt[i].exp_vid);
      check($sformatf("vec%0d_cpu_ack", i), cpu_ack, vt[i].exp_cpu);
      vid_req = 1'b0;
      cpu_req = 1'b0;
      repeat (2) step();
    end

    // Video window: both requesting for a full slot cycle.
    do_reset(2);
    display_active = 1'b1;
    vid_req = 1'b1; vid_addr = 14'h0800;
    cpu_req = 1'b1; cpu_addr = 14'h1235;
    c_vack = 0; c_cack = 0;
    for (int k = 0; k < SM; k++) tick_gap(4);
    check("window_vid_acks", c_vack, 4);
    check("window_cpu_acks", c_cack, 4);
    check("window_vid_data", vid_data, 8'hA5);
    vid_req = 1'b0; cpu_req = 1'b0;
    step();

    // Slot stealing: lone CPU read inside the video window.
    do_reset(2);
    display_active = 1'b1;
    cpu_req = 1'b1; cpu_addr = 14'h1234;
    tick_gap(3);
    check("steal_ack", cpu_ack, 1);
    check("steal_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    step();

    // CPU write then read back.
    c_we = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h3C;
    tick_gap(4);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    check("write_we_cycles", c_we, 1);
    cpu_req = 1'b1;
    tick_gap(3);
    check("readback_ack", cpu_ack, 1);
    check("readback_data", cpu_rdata, 8'h3C);
    cpu_req = 1'b0;
    step();

    // Ticks two clocks apart: every second slot is lost, slot wraps twice.
    do_reset(2);
    cpu_req = 1'b1; cpu_addr = 14'h1236;
    c_cack = 0;
    for (int k = 0; k < 2 * SM; k++) tick_gap(2);
    check("lost_slot_acks", c_cack, SM);
    check("wrap_slot", slot, 0);
    cpu_req = 1'b0;
    repeat (3) step();

    // Reset while in DATA: no ack, bus parks at once, next access is normal.
    cpu_req = 1'b1; cpu_addr = 14'h1237;
    tick_gap(2);
    reset = 1'b1;
    #1;
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_ack", cpu_ack, 0);
    @(posedge clk);
    #1;
    check("midrst_no_ack", cpu_ack, 0);
    do_reset(2);
    cpu_req = 1'b1; cpu_addr = 14'h1237;
    tick_gap(3);
    check("after_rst_ack", cpu_ack, 1);
    check("after_rst_data", cpu_rdata, shadow[14'h1237]);
    cpu_req = 1'b0;
    step();

    // Randomized traffic against the reference model.
    do_reset(2);
    drop_on_ack = 1;
    gap = 3;
    for (int k = 0; k < 1500; k++) begin
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_addr  = AB'(14'h1230 + $urandom_range(0, 15));
        cpu_wdata = DB'($urandom);
      end
      if (!vid_req && $urandom_range(0, 2) == 0) begin
        vid_req  = 1'b1;
        vid_addr = AB'(14'h1230 + $urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) display_active = ~display_active;
      gap--;
      if (gap == 0) begin
        tick = 1'b1;
        gap  = $urandom_range(3, 6);
      end
      step();
    end
    drop_on_ack = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
